// File: rtl/mdu_hilo_pkg.sv
// Shared types and sizing constants for the HI/LO multiply/divide unit.
package mips_mdu_pkg;

   localparam int MDU_WIDTH  = 32;
   localparam int ITER_CNT_W = $clog2(MDU_WIDTH + 1);

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the EXEC stage (master) and the multiply/divide unit (slave).
interface mdu_hilo_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_data, rt_data, mthi, mtlo, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, mthi, mtlo, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mdu_hilo_step.sv
// One iteration of the unit: shift-add multiply step or restoring trial-subtract divide step.
// The accumulator holds {partial_product_hi, multiplier} or {remainder, dividend/quotient}.
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_out
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   // Borrow out of the extended subtract means the divisor did not fit this bit.
   always_comb begin
      sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
              + (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      shifted = acc_in[2*WIDTH-1:WIDTH-1];
      diff    = shifted - {1'b0, operand};
      fits    = ~diff[WIDTH];
      if (is_div) begin
         acc_out = {(fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc_in[WIDTH-2:0], fits};
      end else begin
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning HI/LO: magnitudes are iterated unsigned, then sign-fixed
// in a final cycle. Divide-by-zero and DIV overflow results fall out of the restoring algorithm.
module mdu_hilo
   import mips_mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input logic       clk,
   input logic       reset_n,
   mdu_hilo_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   mdu_state_t         state;
   mdu_state_t         next_state;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] step_acc;
   logic [WIDTH-1:0]   operand;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               is_div;
   logic               neg_lo;
   logic               neg_hi;
   logic               zero_div;
   logic               done_r;
   logic               dbz_r;
   logic               busy_c;

   mdu_op_t            op_v;
   logic               start_signed;
   logic               start_div;
   logic [WIDTH-1:0]   rs_abs;
   logic [WIDTH-1:0]   rt_abs;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc_in  (acc),
      .operand (operand),
      .acc_out (step_acc)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = CALC;
         CALC:    if (count == CNT_W'(WIDTH - 1)) next_state = FIX;
         FIX:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy_c = (state != IDLE);
   end

   // Operand magnitudes at start, and signed corrections applied in FIX.
   always_comb begin
      op_v         = mdu_op_t'(bus.op);
      start_signed = (op_v == MDU_MULT) || (op_v == MDU_DIV);
      start_div    = (op_v == MDU_DIV) || (op_v == MDU_DIVU);
      rs_abs       = (start_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
      rt_abs       = (start_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
      prod_fix     = neg_lo ? -acc : acc;
      quo_fix      = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix      = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count    <= '0;
         acc      <= '0;
         operand  <= '0;
         hi_r     <= '0;
         lo_r     <= '0;
         is_div   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         zero_div <= 1'b0;
         done_r   <= 1'b0;
         dbz_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  count    <= '0;
                  is_div   <= start_div;
                  acc      <= {{WIDTH{1'b0}}, (start_div ? rs_abs : rt_abs)};
                  operand  <= start_div ? rt_abs : rs_abs;
                  neg_lo   <= start_signed && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                  neg_hi   <= start_signed && start_div && bus.rs_data[WIDTH-1];
                  zero_div <= start_div && (bus.rt_data == '0);
               end else begin
                  if (bus.mthi) hi_r <= bus.wdata;
                  if (bus.mtlo) lo_r <= bus.wdata;
               end
            end
            CALC: begin
               acc   <= step_acc;
               count <= count + 1'b1;
            end
            FIX: begin
               if (is_div) begin
                  hi_r <= rem_fix;
                  lo_r <= quo_fix;
               end else begin
                  hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_r <= prod_fix[WIDTH-1:0];
               end
               done_r <= 1'b1;
               dbz_r  <= zero_div;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busy_c;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;
endmodule
